// File: rtl/memory_unit_pkg.sv
// Shared constants and types for the serial-in capture register.
//
// Contents:
//   MU_WIDTH   - number of storage bits in the captured word (16)
//   MU_ADDR_W  - write-address counter width, clog2(MU_WIDTH) (4)
//   mu_addr_t  - write-address type
//   mu_word_t  - captured-word type
package memory_unit_pkg;

  localparam int MU_WIDTH  = 16;
  localparam int MU_ADDR_W = 4;

  typedef logic [MU_ADDR_W-1:0] mu_addr_t;
  typedef logic [MU_WIDTH-1:0]  mu_word_t;

endpackage

// File: rtl/mu_addr_counter.sv
// Free-running write-address counter for memory_unit.
//
// Counts up by one on every rising reclk edge, modulo 2^ADDR_W, and clears
// synchronously on rst. With MEMORY_UNIT_WRAP_FLAG_EN defined it also emits
// a registered terminal-count strobe that is high for the one period after
// the edge on which the count rolls from all-ones back to zero.
//
// Ports:
//   reclk  in   1       rising-edge clock
//   rst    in   1       synchronous active-high reset
//   count  out  ADDR_W  current address (the bit written on the next edge)
//   tc     out  1       terminal-count strobe (MEMORY_UNIT_WRAP_FLAG_EN only)
module mu_addr_counter
  import memory_unit_pkg::*;
#(
  parameter int ADDR_W = MU_ADDR_W
) (
  input  logic              reclk,
  input  logic              rst,
  output logic [ADDR_W-1:0] count
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
  ,
  output logic              tc
`endif
);

  logic [ADDR_W-1:0] count_q;
  logic [ADDR_W-1:0] count_d;

  always_comb begin
    count_d = count_q + ADDR_W'(1);
  end

  always_ff @(posedge reclk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

`ifdef MEMORY_UNIT_WRAP_FLAG_EN
  logic tc_q;
  logic tc_d;

  // The edge that writes the top bit is the one that rolls the count over,
  // so the strobe is set when the pre-edge count is all ones.
  always_comb begin
    tc_d = (count_q == {ADDR_W{1'b1}});
  end

  always_ff @(posedge reclk) begin
    if (rst) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign tc = tc_q;
`endif

endmodule

// File: rtl/memory_unit.sv
// Serial-in, bit-addressed capture register.
//
// On every rising reclk edge the single-bit data input is stored into the
// bit of out selected by the current count, then the count advances. The
// count wraps freely, so after the top bit is written writing continues at
// bit 0 and overwrites the oldest data. Reset clears the word and the count
// on the edge it is sampled; no write happens on a reset edge.
//
// Optional feature macro: MEMORY_UNIT_WRAP_FLAG_EN adds the wrap output.
//
// Parameters:
//   WIDTH   number of storage bits (default 16)
//   ADDR_W  counter width, must equal clog2(WIDTH) (default 4)
//
// Ports:
//   reclk  in   1       rising-edge clock (edge-detected pulse train)
//   rst    in   1       synchronous active-high reset
//   data   in   1       serial bit to store
//   count  out  ADDR_W  current write address
//   out    out  WIDTH   stored word (registered)
//   wrap   out  1       one-period strobe after the edge that writes the top
//                       bit (MEMORY_UNIT_WRAP_FLAG_EN only)
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int WIDTH  = MU_WIDTH,
  parameter int ADDR_W = MU_ADDR_W
) (
  input  logic              reclk,
  input  logic              rst,
  input  logic              data,
  output logic [ADDR_W-1:0] count,
  output logic [WIDTH-1:0]  out
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
  ,
  output logic              wrap
`endif
);

  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  we;
  logic [WIDTH-1:0]  out_q;
  logic [WIDTH-1:0]  out_d;

  mu_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_counter (
    .reclk (reclk),
    .rst   (rst),
    .count (addr)
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
    ,
    .tc    (wrap)
`endif
  );

  // One-hot write enable: exactly one bit of the word is addressed per edge.
  always_comb begin
    we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      we[i] = (addr == ADDR_W'(i));
    end
  end

  // Addressed bit takes data as-is (X/Z included); all others hold.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (we[i]) begin
        out_d[i] = data;
      end
    end
  end

  always_ff @(posedge reclk) begin
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= out_d;
    end
  end

  assign count = addr;
  assign out   = out_q;

endmodule

// File: tb/tb_memory_unit.sv
// Self-checking bench for memory_unit: directed scenarios plus randomized
// data/reset traffic, checked after every edge against a behavioural model
// that tracks "edges since reset" and a plain bit array.
module tb_memory_unit;
  import memory_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic     reclk;
  logic     rst;
  logic     data;
  mu_addr_t count;
  mu_word_t out;
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
  logic     wrap;
`endif

  initial reclk = 1'b0;
  always #5 reclk = ~reclk;

  memory_unit dut (
    .reclk (reclk),
    .rst   (rst),
    .data  (data),
    .count (count),
    .out   (out)
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
    ,
    .wrap  (wrap)
`endif
  );

  // ---------------- scoreboard / model ----------------
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [MU_WIDTH-1:0] exp_q[$];

  int   edges_since_rst = 0;
  logic model_bits [MU_WIDTH];
  logic model_wrap = 1'b0;
  int   wraps_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [MU_WIDTH-1:0] model_word();
    logic [MU_WIDTH-1:0] w;
    for (int i = 0; i < MU_WIDTH; i++) w[i] = model_bits[i];
    return w;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: apply inputs, take one rising edge, update the
  // model, then check the DUT on the following falling edge.
  task automatic step(input logic r, input logic d);
    rst  = r;
    data = d;
    @(posedge reclk);
    if (r) begin
      edges_since_rst = 0;
      for (int i = 0; i < MU_WIDTH; i++) model_bits[i] = 1'b0;
      model_wrap = 1'b0;
    end else begin
      model_bits[edges_since_rst % MU_WIDTH] = d;
      edges_since_rst++;
      model_wrap = (edges_since_rst % MU_WIDTH) == 0;
    end
    exp_q.push_back(model_word());
    @(negedge reclk);
    check("out", 32'(out), 32'(exp_q.pop_front()));
    check("count", 32'(count), 32'(edges_since_rst % MU_WIDTH));
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
    check("wrap", 32'(wrap), 32'(model_wrap));
    if (wrap === 1'b1) wraps_seen++;
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] pat;
    rst  = 1'b1;
    data = 1'b0;
    for (int i = 0; i < MU_WIDTH; i++) model_bits[i] = 1'b0;
    @(negedge reclk);

    // Reset hold with data high
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    check("reset_out", 32'(out), 32'h0);
    check("reset_count", 32'(count), 32'h0);

    // All zeros, wraps twice
    for (int i = 0; i < 36; i++) step(1'b0, 1'b0);
    check("zeros_count_end", 32'(count), 32'd4);
    check("zeros_out_end", 32'(out), 32'h0);

    // Walking fill
    step(1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1);
      check("walk_out", 32'(out), (32'd1 << (i + 1)) - 32'd1);
    end
    check("walk_full", 32'(out), 32'hFFFF);
    check("walk_count", 32'(count), 32'h0);

    // Pattern and overwrite
    step(1'b1, 1'b0);
    pat = 16'hA5C3;
    for (int i = 0; i < 16; i++) step(1'b0, pat[i]);
    check("pattern_out", 32'(out), 32'hA5C3);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
    check("overwrite_out", 32'(out), 32'hA5C0);
    check("overwrite_count", 32'(count), 32'd4);

    // Reset mid-operation
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1);
    check("mid_pre", 32'(out), 32'h007F);
    step(1'b1, 1'b1);
    check("mid_rst_out", 32'(out), 32'h0);
    check("mid_rst_count", 32'(count), 32'h0);
    step(1'b0, 1'b1);
    check("mid_after", 32'(out), 32'h0001);

    // Reset pulse between edges must be ignored
    rst = 1'b1;
    #2;
    step(1'b0, 1'b1);
    check("glitch_out", 32'(out), 32'h0003);
    check("glitch_count", 32'(count), 32'd2);

    // Wrap window: 32 edges of random data after reset release
    step(1'b1, 1'b0);
    wraps_seen = 0;
    for (int i = 0; i < 32; i++) step(1'b0, 1'($urandom_range(0, 1)));
`ifdef MEMORY_UNIT_WRAP_FLAG_EN
    check("wrap_total", 32'(wraps_seen), 32'd2);
`endif

    // Randomized traffic with occasional resets
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
